// File: rtl/inst_encoder_if.sv
// Handshake/bus bundle for inst_encoder.
//   master: the record producer / output consumer (bench or boot sequencer)
//   slave : the encoder itself
// Record channel : in_valid/in_ready with fmt, opcode, rd, rs1, rs2, funct3, funct7, imm
// Address control: load_base, base_addr
// Output channel : out_valid/out_ready with out_inst, out_addr, out_err; err_cnt status
interface inst_encoder_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned ERR_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        fmt;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              load_base;
  logic [ADDR_W-1:0] base_addr;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;
  logic [ERR_W-1:0]  err_cnt;

  modport master (
    output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
    output load_base, base_addr, out_ready,
    input  in_ready, out_valid, out_inst, out_addr, out_err, err_cnt
  );

  modport slave (
    input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
    input  load_base, base_addr, out_ready,
    output in_ready, out_valid, out_inst, out_addr, out_err, err_cnt
  );
endinterface

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs R/I/S/B/U/J field records into 32-bit words,
// tags each word with a sequential byte address and flags unrepresentable
// immediates. One-deep registered output with valid/ready.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : inst_encoder_if.slave (record in, encoded word out, err_cnt)
module inst_encoder #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned ERR_W  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  inst_encoder_if.slave  bus
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_inst_q,  out_inst_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic              out_err_q,   out_err_d;
  logic [ERR_W-1:0]  err_cnt_q,   err_cnt_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;

  logic              in_ready_c;
  logic              accept_c;
  logic [31:0]       inst_c;
  logic              err_c;
  logic [ADDR_W-1:0] base_c;
  logic [ADDR_W-1:0] slot_addr_c;

  // Sign-extension checks: all bits above the field's sign bit must match it.
  logic fits12_c, fits13_c, fits21_c;
  assign fits12_c = (&bus.imm[31:11]) | ~(|bus.imm[31:11]);
  assign fits13_c = (&bus.imm[31:12]) | ~(|bus.imm[31:12]);
  assign fits21_c = (&bus.imm[31:20]) | ~(|bus.imm[31:20]);

  // Field scatter per format; illegal formats fall through to NOP + error.
  always_comb begin
    inst_c = NOP_INST;
    err_c  = 1'b1;
    case (fmt_e'(bus.fmt))
      FMT_R: begin
        inst_c = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
        err_c  = 1'b0;
      end
      FMT_I: begin
        inst_c = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        err_c  = ~fits12_c;
      end
      FMT_S: begin
        inst_c = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
        err_c  = ~fits12_c;
      end
      FMT_B: begin
        inst_c = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                  bus.imm[4:1], bus.imm[11], bus.opcode};
        err_c  = ~fits13_c | bus.imm[0];
      end
      FMT_U: begin
        inst_c = {bus.imm[31:12], bus.rd, bus.opcode};
        err_c  = |bus.imm[11:0];
      end
      FMT_J: begin
        inst_c = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, bus.opcode};
        err_c  = ~fits21_c | bus.imm[0];
      end
      default: begin
        inst_c = NOP_INST;
        err_c  = 1'b1;
      end
    endcase
  end

  assign in_ready_c  = ~out_valid_q | bus.out_ready;
  assign accept_c    = bus.in_valid & in_ready_c;
  assign base_c      = {bus.base_addr[ADDR_W-1:2], 2'b00};
  // A record accepted alongside load_base takes the new base directly.
  assign slot_addr_c = bus.load_base ? base_c : addr_q;

  // Next-state for output register, address counter and saturating error count.
  always_comb begin
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_addr_d  = out_addr_q;
    out_err_d   = out_err_q;
    err_cnt_d   = err_cnt_q;
    addr_d      = addr_q;
    if (accept_c) begin
      out_valid_d = 1'b1;
      out_inst_d  = inst_c;
      out_addr_d  = slot_addr_c;
      out_err_d   = err_c;
      addr_d      = slot_addr_c + ADDR_W'(4);
      if (err_c && (err_cnt_q != {ERR_W{1'b1}})) begin
        err_cnt_d = err_cnt_q + ERR_W'(1);
      end
    end else begin
      if (bus.out_ready) begin
        out_valid_d = 1'b0;
      end
      if (bus.load_base) begin
        addr_d = base_c;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'h0;
      out_addr_q  <= '0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      addr_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_addr_q  <= out_addr_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
      addr_q      <= addr_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_inst  = out_inst_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_err   = out_err_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: a streamed vector table plus hand-written
// backpressure, base-load/wrap and mid-operation reset sequences.
module tb_inst_encoder;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned ERR_W  = 2;

  logic clk;
  logic rst_n;

  inst_encoder_if #(.ADDR_W(ADDR_W), .ERR_W(ERR_W)) bus ();

  inst_encoder #(.ADDR_W(ADDR_W), .ERR_W(ERR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_inst;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  int n_chk;
  int n_fail;
  logic [ADDR_W-1:0] exp_addr;
  logic [ERR_W-1:0]  exp_cnt;

  function automatic vec_t mk(logic [2:0] fmt, logic [6:0] op, logic [4:0] rd,
                              logic [4:0] rs1, logic [4:0] rs2, logic [2:0] f3,
                              logic [6:0] f7, logic [31:0] imm,
                              logic [31:0] exp_inst, logic exp_err);
    vec_t v;
    v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = f3; v.f7 = f7; v.imm = imm; v.exp_inst = exp_inst; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.in_valid = 1'b1;
    bus.fmt      = v.fmt;
    bus.opcode   = v.op;
    bus.rd       = v.rd;
    bus.rs1      = v.rs1;
    bus.rs2      = v.rs2;
    bus.funct3   = v.f3;
    bus.funct7   = v.f7;
    bus.imm      = v.imm;
  endtask

  // Checks one emitted word against the bench's address/error-count model.
  task automatic check_out(input string name, input vec_t v);
    if (v.exp_err && (exp_cnt != 2'd3)) exp_cnt = exp_cnt + 2'd1;
    check({name, ".valid"}, 32'(bus.out_valid), 32'd1);
    check({name, ".inst"},  bus.out_inst, v.exp_inst);
    check({name, ".addr"},  32'(bus.out_addr), 32'(exp_addr));
    check({name, ".err"},   32'(bus.out_err), 32'(v.exp_err));
    check({name, ".cnt"},   32'(bus.err_cnt), 32'(exp_cnt));
    exp_addr = exp_addr + 10'd4;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t va, vb, vc, vd;
    n_chk = 0; n_fail = 0;
    exp_addr = '0; exp_cnt = '0;

    //       fmt  op     rd  rs1 rs2 f3 f7     imm            inst           err
    vecs.push_back(mk(1, 7'h13, 2, 1, 0, 0, 7'h00, 32'h0000_0001, 32'h0010_8113, 0));
    vecs.push_back(mk(2, 7'h23, 0, 2, 3, 2, 7'h00, 32'h0000_0001, 32'h0031_20A3, 0));
    vecs.push_back(mk(3, 7'h63, 0, 1, 2, 0, 7'h00, 32'h0000_0004, 32'h0020_8263, 0));
    vecs.push_back(mk(4, 7'h37, 2, 0, 0, 0, 7'h00, 32'h0000_1000, 32'h0000_1137, 0));
    vecs.push_back(mk(5, 7'h6F, 2, 0, 0, 0, 7'h00, 32'h0000_0004, 32'h0040_016F, 0));
    vecs.push_back(mk(0, 7'h33, 3, 1, 2, 0, 7'h00, 32'hFFFF_FFFF, 32'h0020_81B3, 0));
    vecs.push_back(mk(0, 7'h33, 3, 1, 2, 0, 7'h20, 32'h0000_0000, 32'h4020_81B3, 0));
    vecs.push_back(mk(1, 7'h13, 1, 0, 0, 0, 7'h00, 32'hFFFF_FFFF, 32'hFFF0_0093, 0));
    vecs.push_back(mk(1, 7'h13, 1, 0, 0, 0, 7'h00, 32'hFFFF_F800, 32'h8000_0093, 0));
    vecs.push_back(mk(1, 7'h13, 1, 0, 31, 0, 7'h7F, 32'h0000_07FF, 32'h7FF0_0093, 0));
    vecs.push_back(mk(3, 7'h63, 0, 1, 2, 0, 7'h00, 32'hFFFF_F000, 32'h8020_8063, 0));
    vecs.push_back(mk(5, 7'h6F, 0, 0, 0, 0, 7'h00, 32'hFFFF_FFFE, 32'hFFFF_F06F, 0));
    vecs.push_back(mk(2, 7'h23, 0, 2, 3, 2, 7'h00, 32'hFFFF_FFFF, 32'hFE31_2FA3, 0));
    vecs.push_back(mk(1, 7'h13, 1, 0, 0, 0, 7'h00, 32'h0000_0800, 32'h8000_0093, 1));
    vecs.push_back(mk(3, 7'h63, 0, 1, 2, 0, 7'h00, 32'h0000_0003, 32'h0020_8163, 1));
    vecs.push_back(mk(7, 7'h33, 3, 1, 2, 0, 7'h00, 32'h0000_0000, 32'h0000_0013, 1));
    vecs.push_back(mk(4, 7'h37, 2, 0, 0, 0, 7'h00, 32'h0000_1001, 32'h0000_1137, 1));
    vecs.push_back(mk(3, 7'h63, 0, 1, 2, 0, 7'h00, 32'h0000_1000, 32'h8020_8063, 1));

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.fmt = '0; bus.opcode = '0; bus.rd = '0; bus.rs1 = '0;
    bus.rs2 = '0; bus.funct3 = '0; bus.funct7 = '0; bus.imm = '0;
    bus.load_base = 1'b0; bus.base_addr = '0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    check("rst.valid",    32'(bus.out_valid), 32'd0);
    check("rst.inst",     bus.out_inst, 32'h0);
    check("rst.addr",     32'(bus.out_addr), 32'd0);
    check("rst.err",      32'(bus.out_err), 32'd0);
    check("rst.cnt",      32'(bus.err_cnt), 32'd0);
    check("rst.in_ready", 32'(bus.in_ready), 32'd1);

    // Back-to-back stream: each word must appear exactly one cycle after its record.
    for (int i = 0; i <= vecs.size(); i++) begin
      if (i > 0) check_out($sformatf("vec%0d", i - 1), vecs[i - 1]);
      if (i < vecs.size()) drive(vecs[i]);
      else bus.in_valid = 1'b0;
      @(negedge clk);
    end
    check("drain.valid", 32'(bus.out_valid), 32'd0);

    // Backpressure: A is held while B waits, then B follows exactly once.
    va = mk(1, 7'h13, 5, 0, 0, 0, 7'h00, 32'h5, 32'h0050_0293, 0);
    vb = mk(1, 7'h13, 6, 0, 0, 0, 7'h00, 32'h6, 32'h0060_0313, 0);
    bus.out_ready = 1'b0;
    drive(va);
    @(negedge clk);
    drive(vb);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d.in_ready", k), 32'(bus.in_ready), 32'd0);
      check($sformatf("stall%0d.valid", k),    32'(bus.out_valid), 32'd1);
      check($sformatf("stall%0d.inst", k),     bus.out_inst, va.exp_inst);
      check($sformatf("stall%0d.addr", k),     32'(bus.out_addr), 32'(exp_addr));
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    exp_addr = exp_addr + 10'd4;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_out("bp.B", vb);
    @(negedge clk);
    check("bp.nodup", 32'(bus.out_valid), 32'd0);

    // Base load with an accepted record, then wrap past the top of the space.
    vc = mk(1, 7'h13, 7, 0, 0, 0, 7'h00, 32'h7, 32'h0070_0393, 0);
    vd = mk(1, 7'h13, 8, 0, 0, 0, 7'h00, 32'h8, 32'h0080_0413, 0);
    drive(vc);
    bus.load_base = 1'b1;
    bus.base_addr = 10'h3FF;
    exp_addr = 10'h3FC;
    @(negedge clk);
    bus.load_base = 1'b0;
    check_out("base.C", vc);
    drive(vd);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_out("wrap.D", vd);
    check("wrap.addr0", 32'(bus.out_addr), 32'h000);

    // Base load without a record takes effect for the next one.
    bus.load_base = 1'b1;
    bus.base_addr = 10'h100;
    @(negedge clk);
    bus.load_base = 1'b0;
    drive(vc);
    exp_addr = 10'h100;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_out("base2.C", vc);

    // Reset while a word is pending drops it asynchronously.
    bus.out_ready = 1'b0;
    drive(va);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("prerst.valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst.valid",    32'(bus.out_valid), 32'd0);
    check("arst.inst",     bus.out_inst, 32'h0);
    check("arst.addr",     32'(bus.out_addr), 32'd0);
    check("arst.cnt",      32'(bus.err_cnt), 32'd0);
    check("arst.in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    exp_addr = '0;
    exp_cnt = '0;
    drive(va);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_out("postrst.A", va);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
